// File: rtl/axi_ram_read_responder.sv
`default_nettype none
// ============================================================================
// Module   : axi_ram_read_responder
// Brief    : AXI4 read-channel (AR/R) responder. Each accepted AR burst is
//            turned into a series of 1-cycle-latency reads on the RAM's
//            synchronous read port. Returned words are queued in a 4-entry
//            FIFO, so R backpressure never drops data and bursts stream at
//            one beat per cycle while rready stays high.
// Options  : `define AXI_RD_WRAP_EN to support WRAP bursts (lengths 2/4/8/16).
//            Without it, WRAP is handled exactly like INCR.
// Revision : 1.0 - initial release
// ============================================================================
module axi_ram_read_responder #(
    parameter int DATA_WIDTH     = 64,
    parameter int MEM_DEPTH      = 256,
    parameter int RAM_ADDR_WIDTH = $clog2(MEM_DEPTH),
    parameter int AXI_ADDR_WIDTH = RAM_ADDR_WIDTH + $clog2(DATA_WIDTH / 8),
    parameter int ID_WIDTH       = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [ID_WIDTH-1:0]       s_axi_arid,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]                s_axi_arlen,
    input  logic [1:0]                s_axi_arburst,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    output logic [ID_WIDTH-1:0]       s_axi_rid,
    output logic [DATA_WIDTH-1:0]     s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rlast,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready,
    output logic [RAM_ADDR_WIDTH-1:0] ram_read_addr,
    output logic                      ram_read_enable,
    input  logic [DATA_WIDTH-1:0]     ram_read_data
);

    localparam int BYTE_OFFSET = $clog2(DATA_WIDTH / 8);
    localparam int FIFO_DEPTH  = 4;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [RAM_ADDR_WIDTH-1:0] LAST_WORD = RAM_ADDR_WIDTH'(MEM_DEPTH - 1);

    logic [0:0]                state;
    logic [0:0]                state_next;
    logic                      ar_fire;
    logic                      issue;
    logic                      issue_last;
    logic                      pop;
    logic                      fifo_empty;

    // Burst context latched at AR acceptance
    logic [ID_WIDTH-1:0]       cur_id;
    logic [RAM_ADDR_WIDTH-1:0] cur_addr;
    logic [RAM_ADDR_WIDTH-1:0] addr_mask;
    logic [7:0]                remaining;
    logic [1:0]                cur_resp;

    logic [RAM_ADDR_WIDTH-1:0] ar_word_addr;
    logic [RAM_ADDR_WIDTH-1:0] ar_mask;
    logic [1:0]                ar_resp;
    logic [RAM_ADDR_WIDTH-1:0] incr_addr;
    logic [RAM_ADDR_WIDTH-1:0] next_addr;

    // Read issued last cycle; its data is on ram_read_data now
    logic                      inflight;
    logic                      inflight_last;
    logic [ID_WIDTH-1:0]       inflight_id;
    logic [1:0]                inflight_resp;

    // Output FIFO
    logic [DATA_WIDTH-1:0]     fifo_data [FIFO_DEPTH];
    logic [ID_WIDTH-1:0]       fifo_id   [FIFO_DEPTH];
    logic                      fifo_last [FIFO_DEPTH];
    logic [1:0]                fifo_resp [FIFO_DEPTH];
    logic [1:0]                wr_ptr;
    logic [1:0]                rd_ptr;
    logic [2:0]                fifo_count;
    logic [3:0]                occupancy;

    assign ar_fire      = s_axi_arvalid && s_axi_arready;
    assign ar_word_addr = RAM_ADDR_WIDTH'(s_axi_araddr >> BYTE_OFFSET);
    assign fifo_empty   = (fifo_count == 3'd0);
    assign pop          = s_axi_rvalid && s_axi_rready;
    assign issue_last   = issue && (remaining == 8'd0);

    // Words committed to the FIFO after this cycle, counting the read in flight
    assign occupancy = {1'b0, fifo_count} + {3'b000, inflight} - {3'b000, pop};

    // Address stepping: masked bits advance, unmasked bits hold.
    // FIXED uses an all-zero mask, INCR all-ones, WRAP the low block bits.
    assign incr_addr = (cur_addr == LAST_WORD) ? '0 : cur_addr + RAM_ADDR_WIDTH'(1);
    assign next_addr = (cur_addr & ~addr_mask) | (incr_addr & addr_mask);

`ifdef AXI_RD_WRAP_EN
    logic wrap_len_ok;
    assign wrap_len_ok = (s_axi_arlen == 8'd1) || (s_axi_arlen == 8'd3) ||
                         (s_axi_arlen == 8'd7) || (s_axi_arlen == 8'd15);
`endif

    // Decode burst type into an address-step mask and a response code
    always_comb begin
        ar_mask = '1;
        ar_resp = RESP_OKAY;
        case (s_axi_arburst)
            BURST_FIXED: ar_mask = '0;
            BURST_INCR:  ar_mask = '1;
            BURST_WRAP: begin
`ifdef AXI_RD_WRAP_EN
                if (wrap_len_ok) begin
                    ar_mask = RAM_ADDR_WIDTH'(s_axi_arlen);
                end else begin
                    ar_resp = RESP_SLVERR;
                end
`else
                ar_mask = '1;
`endif
            end
            default: ar_resp = RESP_SLVERR;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state: leave BURST on the issue that exhausts the count
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (ar_fire) state_next = ST_BURST;
            ST_BURST: if (issue_last) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // FSM outputs: accept AR only when idle, issue only if the FIFO has room
    always_comb begin
        s_axi_arready = 1'b0;
        issue         = 1'b0;
        case (state)
            ST_IDLE:  s_axi_arready = 1'b1;
            ST_BURST: issue = (occupancy < 4'd4);
            default:  s_axi_arready = 1'b0;
        endcase
    end

    // Burst context: load on AR, advance address and count on each issue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_id    <= '0;
            cur_addr  <= '0;
            addr_mask <= '0;
            remaining <= '0;
            cur_resp  <= RESP_OKAY;
        end else if (ar_fire) begin
            cur_id    <= s_axi_arid;
            cur_addr  <= ar_word_addr;
            addr_mask <= ar_mask;
            remaining <= s_axi_arlen;
            cur_resp  <= ar_resp;
        end else if (issue) begin
            cur_addr  <= next_addr;
            remaining <= remaining - 8'd1;
        end
    end

    // Tag the outstanding RAM read so its data is captured next cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            inflight_id   <= '0;
            inflight_resp <= RESP_OKAY;
        end else begin
            inflight      <= issue;
            inflight_last <= issue_last;
            inflight_id   <= cur_id;
            inflight_resp <= cur_resp;
        end
    end

    // FIFO storage; outputs are gated while empty, so no reset is needed here
    always_ff @(posedge clk) begin
        if (inflight) begin
            fifo_data[wr_ptr] <= ram_read_data;
            fifo_id[wr_ptr]   <= inflight_id;
            fifo_last[wr_ptr] <= inflight_last;
            fifo_resp[wr_ptr] <= inflight_resp;
        end
    end

    // FIFO pointers and fill count; push and pop may coincide
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (inflight) wr_ptr <= wr_ptr + 2'd1;
            if (pop)      rd_ptr <= rd_ptr + 2'd1;
            case ({inflight, pop})
                2'b10:   fifo_count <= fifo_count + 3'd1;
                2'b01:   fifo_count <= fifo_count - 3'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // R channel is the FIFO head, forced to zero while nothing is queued
    always_comb begin
        s_axi_rvalid = !fifo_empty;
        s_axi_rid    = fifo_empty ? '0 : fifo_id[rd_ptr];
        s_axi_rdata  = fifo_empty ? '0 : fifo_data[rd_ptr];
        s_axi_rresp  = fifo_empty ? RESP_OKAY : fifo_resp[rd_ptr];
        s_axi_rlast  = fifo_empty ? 1'b0 : fifo_last[rd_ptr];
    end

    assign ram_read_enable = issue;
    assign ram_read_addr   = cur_addr;

endmodule
`default_nettype wire

// File: doc/axi_ram_read_responder.md
# axi_ram_read_responder

AXI4 read-channel responder that serves AR/R bursts from the synchronous read port of the team's dual-port RAM. It turns each accepted AR burst into a sequence of 1-cycle-latency RAM reads. Returned words pass through a 4-entry output FIFO, so R-channel backpressure never loses data and the block sustains one beat per cycle while `s_axi_rready` stays high. It sits between the AXI interconnect and the RAM's read port; write traffic reaches the RAM through a separate path.

## Interface
- `DATA_WIDTH`, 64, data width in bits (multiple of 8).
- `MEM_DEPTH`, 256, RAM depth in words.
- `RAM_ADDR_WIDTH`, $clog2(MEM_DEPTH), RAM word-address width.
- `AXI_ADDR_WIDTH`, RAM_ADDR_WIDTH+$clog2(DATA_WIDTH/8), AXI byte-address width.
- `ID_WIDTH`, 4, AXI ID width.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `s_axi_arid` in ID_WIDTH: burst ID.
- `s_axi_araddr` in AXI_ADDR_WIDTH: byte address; low $clog2(DATA_WIDTH/8) bits ignored.
- `s_axi_arlen` in 8: beats minus 1.
- `s_axi_arburst` in 2: 00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
- `s_axi_arvalid` in 1 / `s_axi_arready` out 1: AR handshake.
- `s_axi_rid` out ID_WIDTH, `s_axi_rdata` out DATA_WIDTH, `s_axi_rresp` out 2, `s_axi_rlast` out 1: R payload.
- `s_axi_rvalid` out 1 / `s_axi_rready` in 1: R handshake.
- `ram_read_addr` out RAM_ADDR_WIDTH: RAM word address.
- `ram_read_enable` out 1: RAM read strobe.
- `ram_read_data` in DATA_WIDTH: RAM data, valid the cycle after `ram_read_enable`; the RAM holds it while the enable is low.

## Operation
- States: IDLE and BURST.
- IDLE:
  - `s_axi_arready`=1.
  - On `arvalid&&arready`: latch ID, word address (`araddr>>log2(DATA_WIDTH/8)`), remaining count `arlen`, burst type and response; go to BURST.
- BURST:
  - `s_axi_arready`=0.
  - Issue a read (`ram_read_enable`=1) in any cycle where `fifo_count + inflight - pop < 4`. `pop` = R handshake this cycle; `inflight` = read issued last cycle.
  - The issue that brings the remaining count to 0 tags the beat last and returns the FSM to IDLE; the next AR may be accepted in the following cycle.
- Address update after each issue:
  - FIXED: unchanged.
  - INCR: +1, wrapping modulo MEM_DEPTH.
  - reserved 11: INCR addressing, RRESP=SLVERR (2'b10) on every beat.
  - WRAP: see Configuration.
- Capture: a 1-cycle `inflight` flag pushes `ram_read_data` into the FIFO, together with ID, last and resp, one cycle after the issue.
- The FIFO head drives R outputs: `s_axi_rvalid` = FIFO not empty; pop on `rvalid&&rready`. Push and pop may occur in the same cycle.
- A full FIFO with `rready`=0 stalls issue. R payload is held stable while `rvalid&&!rready`.
- Bursts never interleave; beats return in issue order.

## Timing
- Reset (async assert, sync release): FSM in IDLE, FIFO empty, inflight=0.
  - Output reset values: `s_axi_arready`=1 after release, `s_axi_rvalid`=0, `s_axi_rlast`=0, `s_axi_rresp`=0, `s_axi_rid`=0, `s_axi_rdata`=0, `ram_read_enable`=0, `ram_read_addr`=0.
- Latency: AR handshake in cycle T; first RAM read issued in T+1; first `rvalid` in T+3.
- With `rready` held 1, beats occur in consecutive cycles, and `rlast` appears in T+3+arlen.
- Back-to-back bursts: a gap of exactly one cycle on AR (IDLE turnaround). R may stream without a bubble if the FIFO holds data.
- Reset mid-burst discards all in-flight and buffered beats; no partial beat appears after release.

## Configuration
- `AXI_RD_WRAP_EN` defined:
  - WRAP bursts with arlen ∈ {1,3,7,15} wrap within an aligned block of arlen+1 words.
  - WRAP with any other arlen returns SLVERR on every beat, with INCR addressing.
- Undefined: WRAP (10) is treated exactly as INCR with RRESP=OKAY.

## Test plan
- Single beat: araddr=0x40, arlen=0, INCR, RAM word 8 = 0xA5 -> `rvalid` at T+3, rdata=0xA5, rlast=1, rresp=0, rid=arid.
- INCR arlen=7 from word 252 with `rready`=1 -> 8 consecutive beats: words 252..255, then 0..3; rlast only on the 8th.
- Backpressure: arlen=15, `rready` toggled 1-0-0-1… -> all 16 words delivered in order; no duplicates or losses; payload stable while stalled; `ram_read_enable` never raised with the FIFO full.
- FIXED arlen=3 at word 5 -> `ram_read_addr`=5 for all 4 issues; 4 beats of word 5.
- `AXI_RD_WRAP_EN` on, WRAP arlen=3 at word 6 -> words 6,7,4,5. Macro off -> words 6,7,8,9. With the macro on, arburst=11 gives rresp=2 on all beats.
- Assert `rst_n` low mid-burst after 2 of 8 beats -> `rvalid`=0 immediately; after release, `arready`=1 and a new burst returns correct data.
